// File: rtl/ccip_c1tx_wrbuf_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : ccip_c1tx_wrbuf_if
// Purpose  : Upstream write-request, FIU channel-1 TX/RX and status bundle.
// Revision : 1.0
//------------------------------------------------------------------------------
interface ccip_c1tx_wrbuf_if;
  localparam int CCIP_CLDATA_WIDTH   = 512;
  localparam int CCIP_C1TX_HDR_WIDTH = 80;
  localparam int CCIP_C1RX_HDR_WIDTH = 28;

  logic                           in_valid;
  logic                           in_ready;
  logic [41:0]                    in_addr;
  logic [CCIP_CLDATA_WIDTH-1:0]   in_data;
  logic                           c1TxAlmFull;
  logic [CCIP_C1TX_HDR_WIDTH-1:0] c1Tx_hdr;
  logic [CCIP_CLDATA_WIDTH-1:0]   c1Tx_data;
  logic                           c1Tx_valid;
  logic [CCIP_C1RX_HDR_WIDTH-1:0] c1Rx_hdr;
  logic                           c1Rx_rspValid;
  logic                           idle;
  logic                           err_underflow;

  modport slave (
    input  in_valid, in_addr, in_data, c1TxAlmFull, c1Rx_hdr, c1Rx_rspValid,
    output in_ready, c1Tx_hdr, c1Tx_data, c1Tx_valid, idle, err_underflow
  );

  modport master (
    output in_valid, in_addr, in_data, c1TxAlmFull, c1Rx_hdr, c1Rx_rspValid,
    input  in_ready, c1Tx_hdr, c1Tx_data, c1Tx_valid, idle, err_underflow
  );
endinterface
`default_nettype wire

// File: rtl/ccip_c1tx_wrbuf.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : ccip_c1tx_wrbuf
// Purpose  : CCI-P channel-1 write buffer: FIFO of WrLine requests issued
//            under AlmFull back-pressure and an outstanding-write cap.
//            Optional counters: define C1TX_WRBUF_STATS_EN.
// Revision : 1.0
//------------------------------------------------------------------------------
module ccip_c1tx_wrbuf #(
  parameter int DEPTH           = 16,
  parameter int MAX_OUTSTANDING = 64
) (
  input  wire logic        pClk,
  input  wire logic        pck_cp2af_softReset,
`ifdef C1TX_WRBUF_STATS_EN
  output logic [31:0]      stat_issued,
  output logic [31:0]      stat_stall,
`endif
  ccip_c1tx_wrbuf_if.slave bus
);
  localparam int             c_CL_W        = 512;
  localparam int             c_HDR_W       = 80;
  localparam int             c_AW          = $clog2(DEPTH);
  localparam int             c_ENT_W       = 42 + c_CL_W;
  localparam logic [8:0]     c_MAX_OUT     = MAX_OUTSTANDING[8:0];
  localparam logic [3:0]     c_REQ_WRLINE_I = 4'h0;
  localparam logic [1:0]     c_VC_VA        = 2'b00;
  localparam logic [1:0]     c_CL_LEN_1     = 2'b00;
  localparam logic [3:0]     c_RSP_WRLINE   = 4'h0;

  logic [c_ENT_W-1:0] fifo_mem_q [DEPTH];
  logic [c_AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [7:0]         out_q, out_d;
  logic [15:0]        seq_q, seq_d;
  logic               err_q, err_d;
  logic               tx_valid_q, tx_valid_d;
  logic [c_HDR_W-1:0] tx_hdr_q, tx_hdr_d;
  logic [c_CL_W-1:0]  tx_data_q, tx_data_d;

  logic               w_empty, w_full, w_push, w_issue, w_wr_rsp;
  logic [c_ENT_W-1:0] w_head;
  logic               w_unused_rxhdr;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  assign w_empty  = (wr_ptr_q == rd_ptr_q);
  assign w_full   = (wr_ptr_q[c_AW] != rd_ptr_q[c_AW]) &&
                    (wr_ptr_q[c_AW-1:0] == rd_ptr_q[c_AW-1:0]);
  assign w_push   = bus.in_valid && bus.in_ready;
  assign w_issue  = !w_empty && !bus.c1TxAlmFull && ({1'b0, out_q} < c_MAX_OUT);
  assign w_wr_rsp = bus.c1Rx_rspValid && (bus.c1Rx_hdr[19:16] == c_RSP_WRLINE);
  assign w_head   = fifo_mem_q[rd_ptr_q[c_AW-1:0]];
  assign w_unused_rxhdr = ^{bus.c1Rx_hdr[27:20], bus.c1Rx_hdr[15:0]};

  assign bus.in_ready      = !pck_cp2af_softReset && !w_full;
  assign bus.c1Tx_valid    = tx_valid_q;
  assign bus.c1Tx_hdr      = tx_hdr_q;
  assign bus.c1Tx_data     = tx_data_q;
  assign bus.err_underflow = err_q;
  assign bus.idle          = w_empty && (out_q == 8'd0) && !tx_valid_q;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    seq_d      = seq_q;
    out_d      = out_q;
    err_d      = err_q;
    tx_valid_d = w_issue;
    tx_hdr_d   = tx_hdr_q;
    tx_data_d  = tx_data_q;
    if (w_push) wr_ptr_d = wr_ptr_q + (c_AW+1)'(1);
    if (w_issue) begin
      rd_ptr_d  = rd_ptr_q + (c_AW+1)'(1);
      seq_d     = seq_q + 16'd1;
      tx_hdr_d  = {6'b0, c_VC_VA, 1'b1, 1'b0, c_CL_LEN_1, c_REQ_WRLINE_I, 6'b0,
                   w_head[c_ENT_W-1 -: 42], seq_q};
      tx_data_d = w_head[c_CL_W-1:0];
    end
    // A simultaneous issue and write response cancel; a lone response at zero is an underflow.
    if (w_issue && !w_wr_rsp) begin
      out_d = out_q + 8'd1;
    end else if (!w_issue && w_wr_rsp) begin
      if (out_q == 8'd0) err_d = 1'b1;
      else               out_d = out_q - 8'd1;
    end
  end

  always_ff @(posedge pClk) begin
    if (pck_cp2af_softReset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      seq_q      <= '0;
      out_q      <= '0;
      err_q      <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_hdr_q   <= '0;
      tx_data_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      seq_q      <= seq_d;
      out_q      <= out_d;
      err_q      <= err_d;
      tx_valid_q <= tx_valid_d;
      tx_hdr_q   <= tx_hdr_d;
      tx_data_q  <= tx_data_d;
    end
  end

  always_ff @(posedge pClk) begin
    if (w_push) fifo_mem_q[wr_ptr_q[c_AW-1:0]] <= {bus.in_addr, bus.in_data};
  end

`ifdef C1TX_WRBUF_STATS_EN
  logic [31:0] stat_issued_q, stat_stall_q;

  always_ff @(posedge pClk) begin
    if (pck_cp2af_softReset) begin
      stat_issued_q <= '0;
      stat_stall_q  <= '0;
    end else begin
      if (w_issue)             stat_issued_q <= stat_issued_q + 32'd1;
      if (!w_empty && !w_issue) stat_stall_q <= stat_stall_q + 32'd1;
    end
  end

  assign stat_issued = stat_issued_q;
  assign stat_stall  = stat_stall_q;
`endif
endmodule
`default_nettype wire

// File: tb/tb_ccip_c1tx_wrbuf.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_ccip_c1tx_wrbuf
// Purpose  : Self-checking bench: directed vector table, corner sequences and
//            random traffic against a queue-based reference model.
// Revision : 1.0
//------------------------------------------------------------------------------
module tb_ccip_c1tx_wrbuf;
  localparam int DEPTH = 16;
  localparam int MAXO  = 4;

  logic pClk = 1'b0;
  logic rst  = 1'b0;
  always #5 pClk = ~pClk;

  ccip_c1tx_wrbuf_if bus();
`ifdef C1TX_WRBUF_STATS_EN
  logic [31:0] stat_issued, stat_stall;
`endif

  ccip_c1tx_wrbuf #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
    .pClk                (pClk),
    .pck_cp2af_softReset (rst),
`ifdef C1TX_WRBUF_STATS_EN
    .stat_issued         (stat_issued),
    .stat_stall          (stat_stall),
`endif
    .bus                 (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed { logic [41:0] addr; logic [511:0] data; } ent_t;
  ent_t         mq[$];
  int           m_out   = 0;
  logic [15:0]  m_seq   = 16'h0;
  bit           m_err   = 1'b0;
  bit           m_vld   = 1'b0;
  logic [41:0]  m_addr  = '0;
  logic [511:0] m_data  = '0;
  logic [15:0]  m_mdata = '0;
  logic [31:0]  m_iss   = '0;
  logic [31:0]  m_stall = '0;
  bit           last_rdy;

  task automatic check(input string nm, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [79:0] exp_hdr(input logic [41:0] a, input logic [15:0] md);
    // rsvd, vc_sel=VA, sop=1, rsvd, cl_len=1CL, req_type=WrLine_I, rsvd, address, mdata
    return {6'b0, 2'b00, 1'b1, 1'b0, 2'b00, 4'h0, 6'b0, a, md};
  endfunction

  task automatic cyc(input bit r, input bit iv, input logic [41:0] a, input logic [511:0] d,
                     input bit alm, input bit rv, input logic [3:0] rt);
    bit rdy, iss, wrsp;
    ent_t e;
    rst = r;
    bus.in_valid = iv;
    bus.in_addr = a;
    bus.in_data = d;
    bus.c1TxAlmFull = alm;
    bus.c1Rx_rspValid = rv;
    bus.c1Rx_hdr = {8'h00, rt, 16'h0000};
    #1;
    rdy  = !r && (mq.size() < DEPTH);
    last_rdy = bus.in_ready;
    check("in_ready", 512'(bus.in_ready), 512'(rdy));
    iss  = !r && (mq.size() > 0) && !alm && (m_out < MAXO);
    wrsp = rv && (rt == 4'h0);
    if (r) begin
      mq.delete();
      m_out = 0; m_seq = 16'h0; m_err = 1'b0; m_vld = 1'b0; m_iss = '0; m_stall = '0;
    end else begin
      m_vld = iss;
      if (iss) begin
        e = mq.pop_front();
        m_addr = e.addr; m_data = e.data; m_mdata = m_seq;
        m_seq++; m_iss++;
      end else if (mq.size() > 0) begin
        m_stall++;
      end
      if (iv && rdy) mq.push_back({a, d});
      if (wrsp && !iss) begin
        if (m_out == 0) m_err = 1'b1;
        else            m_out--;
      end else if (iss && !wrsp) begin
        m_out++;
      end
    end
    @(posedge pClk);
    #1;
    check("c1Tx_valid", 512'(bus.c1Tx_valid), 512'(m_vld));
    if (m_vld) begin
      check("c1Tx_hdr", 512'(bus.c1Tx_hdr), 512'(exp_hdr(m_addr, m_mdata)));
      check("c1Tx_data", bus.c1Tx_data, m_data);
    end
    check("idle", 512'(bus.idle), 512'(mq.size() == 0 && m_out == 0 && !m_vld));
    check("err_underflow", 512'(bus.err_underflow), 512'(m_err));
`ifdef C1TX_WRBUF_STATS_EN
    check("stat_issued", 512'(stat_issued), 512'(m_iss));
    check("stat_stall", 512'(stat_stall), 512'(m_stall));
`endif
  endtask

  task automatic idle_cyc(input bit rv);
    cyc(1'b0, 1'b0, 42'h0, 512'h0, 1'b0, rv, 4'h0);
  endtask

  typedef struct {
    bit r; bit iv; logic [41:0] a; bit alm; bit rv; logic [3:0] rt;
    bit e_rdy; bit e_vld; logic [41:0] e_addr; logic [15:0] e_md; bit e_idle; bit e_err;
  } vec_t;
  vec_t tbl[12];

  initial begin
    int n, cnt;
    bit prev;
    logic [15:0] last_md;

    tbl[0]  = '{1'b1, 1'b0, 42'h0,   1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 42'h0,   16'h0, 1'b1, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 42'h100, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 42'h0,   16'h0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 42'h0,   1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 42'h100, 16'h0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 42'h0,   1'b0, 1'b1, 4'h0, 1'b1, 1'b0, 42'h0,   16'h0, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 42'h0,   1'b0, 1'b1, 4'h0, 1'b1, 1'b0, 42'h0,   16'h0, 1'b1, 1'b1};
    tbl[5]  = '{1'b0, 1'b0, 42'h0,   1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 42'h0,   16'h0, 1'b1, 1'b1};
    tbl[6]  = '{1'b1, 1'b0, 42'h0,   1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 42'h0,   16'h0, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 42'h0,   1'b0, 1'b1, 4'h4, 1'b1, 1'b0, 42'h0,   16'h0, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 42'h2A5, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 42'h0,   16'h0, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 42'h0,   1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 42'h0,   16'h0, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 42'h0,   1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 42'h2A5, 16'h0, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 42'h0,   1'b0, 1'b1, 4'h0, 1'b1, 1'b0, 42'h0,   16'h0, 1'b1, 1'b0};

    for (int i = 0; i < 12; i++) begin
      cyc(tbl[i].r, tbl[i].iv, tbl[i].a, {16{32'hC0DE0000 + 32'(i)}},
          tbl[i].alm, tbl[i].rv, tbl[i].rt);
      check("tbl_in_ready", 512'(last_rdy), 512'(tbl[i].e_rdy));
      check("tbl_valid", 512'(bus.c1Tx_valid), 512'(tbl[i].e_vld));
      if (tbl[i].e_vld) begin
        check("tbl_addr", 512'(bus.c1Tx_hdr[57:16]), 512'(tbl[i].e_addr));
        check("tbl_mdata", 512'(bus.c1Tx_hdr[15:0]), 512'(tbl[i].e_md));
      end
      check("tbl_idle", 512'(bus.idle), 512'(tbl[i].e_idle));
      check("tbl_err", 512'(bus.err_underflow), 512'(tbl[i].e_err));
    end

    // Fill under AlmFull, then drain in order while acknowledging each write.
    cyc(1'b1, 1'b0, 42'h0, 512'h0, 1'b0, 1'b0, 4'h0);
    for (int i = 0; i < 16; i++)
      cyc(1'b0, 1'b1, 42'h1000 + 42'(i), {16{32'(i)}}, 1'b1, 1'b0, 4'h0);
    cyc(1'b0, 1'b1, 42'h3FF, 512'h0, 1'b1, 1'b0, 4'h0);
    check("full_in_ready", 512'(last_rdy), 512'd0);
    n = 0; prev = 1'b0;
    for (int c = 0; c < 200 && n < 16; c++) begin
      cyc(1'b0, 1'b0, 42'h0, 512'h0, 1'b0, prev, 4'h0);
      if (bus.c1Tx_valid) begin
        check("drain_mdata", 512'(bus.c1Tx_hdr[15:0]), 512'(n));
        check("drain_addr", 512'(bus.c1Tx_hdr[57:16]), 512'(42'h1000 + 42'(n)));
        n++;
      end
      prev = bus.c1Tx_valid;
    end
    check("drain_count", 512'(n), 512'd16);

    // Outstanding cap: 8 pushes, no responses.
    cyc(1'b1, 1'b0, 42'h0, 512'h0, 1'b0, 1'b0, 4'h0);
    cnt = 0;
    for (int i = 0; i < 28; i++) begin
      cyc(1'b0, i < 8, 42'h2000 + 42'(i), {16{32'hA5A50000 + 32'(i)}}, 1'b0, 1'b0, 4'h0);
      if (bus.c1Tx_valid) cnt++;
    end
    check("cap_issues", 512'(cnt), 512'd4);
    idle_cyc(1'b1);
    if (bus.c1Tx_valid) cnt++;
    for (int i = 0; i < 10; i++) begin
      idle_cyc(1'b0);
      if (bus.c1Tx_valid) cnt++;
    end
    check("cap_after_rsp", 512'(cnt), 512'd5);

    // Issue and write response in the same cycle with three outstanding.
    cyc(1'b1, 1'b0, 42'h0, 512'h0, 1'b0, 1'b0, 4'h0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 42'h30 + 42'(i), 512'(i), 1'b0, 1'b0, 4'h0);
    for (int i = 0; i < 4; i++) idle_cyc(1'b0);
    cyc(1'b0, 1'b1, 42'h33, 512'h3, 1'b0, 1'b0, 4'h0);
    idle_cyc(1'b1);
    check("same_cycle_issue", 512'(bus.c1Tx_valid), 512'd1);
    idle_cyc(1'b0);
    idle_cyc(1'b1);
    idle_cyc(1'b1);
    check("out3_not_idle", 512'(bus.idle), 512'd0);
    idle_cyc(1'b1);
    check("out3_idle", 512'(bus.idle), 512'd1);
    check("out3_no_err", 512'(bus.err_underflow), 512'd0);
    idle_cyc(1'b1);
    check("out3_underflow", 512'(bus.err_underflow), 512'd1);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      cyc($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 6,
          {10'($urandom), 32'($urandom)}, {16{$urandom}},
          $urandom_range(0, 3) == 0, $urandom_range(0, 9) < 3,
          ($urandom_range(0, 3) == 0) ? 4'h4 : 4'h0);
    end

    // Sequence number wrap over 65537 issues.
    cyc(1'b1, 1'b0, 42'h0, 512'h0, 1'b0, 1'b0, 4'h0);
    n = 0; prev = 1'b0; last_md = 16'hDEAD;
    for (int c = 0; c < 70000 && n < 65537; c++) begin
      cyc(1'b0, 1'b1, 42'(c), {480'h0, 32'(c)}, 1'b0, prev, 4'h0);
      if (bus.c1Tx_valid) begin
        n++;
        last_md = bus.c1Tx_hdr[15:0];
      end
      prev = bus.c1Tx_valid;
    end
    check("wrap_issue_count", 512'(n), 512'd65537);
    check("wrap_final_mdata", 512'(last_md), 512'h0);
`ifdef C1TX_WRBUF_STATS_EN
    check("wrap_stat_issued", 512'(stat_issued), 512'd65537);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
